mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle for the two-master arbiter: master 0/1 request sides plus the crossbar port.
// All signals are combinational pass-through wires; no state lives here.
// The slave modport is the arbiter's view, the master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              i_m0_req;
  logic              i_m0_lock;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [31:0]       i_m0_data;
  logic              i_m0_wren;
  logic [3:0]        i_m0_mask;
  logic              o_m0_gnt;
  logic              o_m0_rvalid;
  logic [31:0]       o_m0_rdata;

  logic              i_m1_req;
  logic              i_m1_lock;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [31:0]       i_m1_data;
  logic              i_m1_wren;
  logic [3:0]        i_m1_mask;
  logic              o_m1_gnt;
  logic              o_m1_rvalid;
  logic [31:0]       o_m1_rdata;

  logic              o_mem_valid;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_data;
  logic              o_mem_wren;
  logic [3:0]        o_mem_mask;
  logic [31:0]       i_mem_data;

  modport slave (
    input  i_m0_req, i_m0_lock, i_m0_addr, i_m0_data, i_m0_wren, i_m0_mask,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    input  i_m1_req, i_m1_lock, i_m1_addr, i_m1_data, i_m1_wren, i_m1_mask,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    output o_mem_valid, o_mem_addr, o_mem_data, o_mem_wren, o_mem_mask,
    input  i_mem_data
  );

  modport master (
    output i_m0_req, i_m0_lock, i_m0_addr, i_m0_data, i_m0_wren, i_m0_mask,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    output i_m1_req, i_m1_lock, i_m1_addr, i_m1_data, i_m1_wren, i_m1_mask,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    input  o_mem_valid, o_mem_addr, o_mem_data, o_mem_wren, o_mem_mask,
    output i_mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter with bus lock onto the single data-memory port.
// Latency: grant same cycle as request; read data returns READ_LATENCY cycles after grant.
// Backpressure: a master waits with req held until gnt; returned read data cannot be stalled.
module mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 30
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  // Round-robin pointer: id of the most recently granted master.
  logic last_grant;
  // Bus lock: when valid, only lock_id may be granted.
  logic lock_vld;
  logic lock_id;

  // Owner-tag pipeline; stage READ_LATENCY-1 lines up with i_mem_data.
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_id;

  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic              gnt_id;
  logic              owner_req;
  logic              sel_lock;
  logic              sel_wren;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_data;
  logic [3:0]        sel_mask;

  // Grant decision: lock owner only, else single requester, else alternate.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (lock_vld) begin
        if (lock_id) gnt1 = bus.i_m1_req;
        else         gnt0 = bus.i_m0_req;
      end else if (bus.i_m0_req && bus.i_m1_req) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = bus.i_m0_req;
        gnt1 = bus.i_m1_req;
      end
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign owner_req = lock_id ? bus.i_m1_req : bus.i_m0_req;

  // Payload mux; master 0 is presented when nobody is granted.
  always_comb begin
    if (gnt_id) begin
      sel_lock = bus.i_m1_lock;
      sel_wren = bus.i_m1_wren;
      sel_addr = bus.i_m1_addr;
      sel_data = bus.i_m1_data;
      sel_mask = bus.i_m1_mask;
    end else begin
      sel_lock = bus.i_m0_lock;
      sel_wren = bus.i_m0_wren;
      sel_addr = bus.i_m0_addr;
      sel_data = bus.i_m0_data;
      sel_mask = bus.i_m0_mask;
    end
  end

  assign bus.o_m0_gnt    = gnt0;
  assign bus.o_m1_gnt    = gnt1;
  assign bus.o_mem_valid = gnt_any;
  assign bus.o_mem_addr  = sel_addr;
  assign bus.o_mem_data  = sel_data;
  assign bus.o_mem_mask  = sel_mask;
  assign bus.o_mem_wren  = sel_wren & gnt_any;

  // Track last grant and lock ownership; an idle owner releases the lock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant <= 1'b1;
      lock_vld   <= 1'b0;
      lock_id    <= 1'b0;
    end else if (gnt_any) begin
      last_grant <= gnt_id;
      lock_vld   <= sel_lock;
      lock_id    <= gnt_id;
    end else if (lock_vld && !owner_req) begin
      lock_vld   <= 1'b0;
    end
  end

  // Shift read-owner tags so returning data is steered to the issuing master.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= gnt_any & !sel_wren;
      tag_id[0]  <= gnt_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign bus.o_m0_rvalid = tag_vld[READ_LATENCY-1] & !tag_id[READ_LATENCY-1];
  assign bus.o_m1_rvalid = tag_vld[READ_LATENCY-1] &  tag_id[READ_LATENCY-1];
  assign bus.o_m0_rdata  = bus.i_mem_data;
  assign bus.o_m1_rdata  = bus.i_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 3) share one stimulus stream.
// Expected grants, crossbar outputs and read returns come from a cycle-level reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_arbiter;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req  [2];
  logic          lck  [2];
  logic          wren [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   wdat [2];
  logic [3:0]    mask [2];
  logic [31:0]   mem_rd;

  mem_arbiter_if #(.ADDR_W(AW)) bus1 ();
  mem_arbiter_if #(.ADDR_W(AW)) bus3 ();

  assign bus1.i_m0_req  = req[0];  assign bus3.i_m0_req  = req[0];
  assign bus1.i_m0_lock = lck[0];  assign bus3.i_m0_lock = lck[0];
  assign bus1.i_m0_addr = addr[0]; assign bus3.i_m0_addr = addr[0];
  assign bus1.i_m0_data = wdat[0]; assign bus3.i_m0_data = wdat[0];
  assign bus1.i_m0_wren = wren[0]; assign bus3.i_m0_wren = wren[0];
  assign bus1.i_m0_mask = mask[0]; assign bus3.i_m0_mask = mask[0];
  assign bus1.i_m1_req  = req[1];  assign bus3.i_m1_req  = req[1];
  assign bus1.i_m1_lock = lck[1];  assign bus3.i_m1_lock = lck[1];
  assign bus1.i_m1_addr = addr[1]; assign bus3.i_m1_addr = addr[1];
  assign bus1.i_m1_data = wdat[1]; assign bus3.i_m1_data = wdat[1];
  assign bus1.i_m1_wren = wren[1]; assign bus3.i_m1_wren = wren[1];
  assign bus1.i_m1_mask = mask[1]; assign bus3.i_m1_mask = mask[1];
  assign bus1.i_mem_data = mem_rd; assign bus3.i_mem_data = mem_rd;

  mem_arbiter #(.READ_LATENCY(1), .ADDR_W(AW)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));
  mem_arbiter #(.READ_LATENCY(3), .ADDR_W(AW)) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3.slave));

  // Reference model state: last granted master, lock owner (-1 = none),
  // and per-cycle expected read return (0 = none, 1 = master 0, 2 = master 1).
  int m_last;
  int m_lock;
  int sched1 [8];
  int sched3 [8];
  int cyc;
  int g_now;
  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int exp_grant();
    if (rst) return -1;
    if (m_lock >= 0) return req[m_lock] ? m_lock : -1;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic eval_cycle();
    int sel;
    int e1;
    int e3;
    #1;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        sched1[k] = 0;
        sched3[k] = 0;
      end
      m_last = 1;
      m_lock = -1;
    end
    g_now = exp_grant();
    sel   = (g_now == 1) ? 1 : 0;
    check("d1_gnt0",  bus1.o_m0_gnt,    g_now == 0);
    check("d1_gnt1",  bus1.o_m1_gnt,    g_now == 1);
    check("d3_gnt0",  bus3.o_m0_gnt,    g_now == 0);
    check("d3_gnt1",  bus3.o_m1_gnt,    g_now == 1);
    check("d1_valid", bus1.o_mem_valid, g_now >= 0);
    check("d3_valid", bus3.o_mem_valid, g_now >= 0);
    check("d1_addr",  32'(bus1.o_mem_addr), 32'(addr[sel]));
    check("d1_data",  bus1.o_mem_data,  wdat[sel]);
    check("d1_mask",  32'(bus1.o_mem_mask), 32'(mask[sel]));
    check("d1_wren",  bus1.o_mem_wren,  (g_now >= 0) && wren[sel]);
    check("d3_wren",  bus3.o_mem_wren,  (g_now >= 0) && wren[sel]);
    e1 = sched1[cyc % 8];
    sched1[cyc % 8] = 0;
    e3 = sched3[cyc % 8];
    sched3[cyc % 8] = 0;
    check("d1_rvalid0", bus1.o_m0_rvalid, e1 == 1);
    check("d1_rvalid1", bus1.o_m1_rvalid, e1 == 2);
    check("d3_rvalid0", bus3.o_m0_rvalid, e3 == 1);
    check("d3_rvalid1", bus3.o_m1_rvalid, e3 == 2);
    if (e1 == 1) check("d1_rdata0", bus1.o_m0_rdata, mem_rd);
    if (e1 == 2) check("d1_rdata1", bus1.o_m1_rdata, mem_rd);
    if (e3 == 1) check("d3_rdata0", bus3.o_m0_rdata, mem_rd);
    if (e3 == 2) check("d3_rdata1", bus3.o_m1_rdata, mem_rd);
  endtask

  task automatic end_cycle();
    if (!rst && g_now >= 0 && !wren[g_now]) begin
      sched1[(cyc + 1) % 8] = g_now + 1;
      sched3[(cyc + 3) % 8] = g_now + 1;
    end
    if (!rst) begin
      if (g_now >= 0) begin
        m_last = g_now;
        m_lock = lck[g_now] ? g_now : -1;
      end else if (m_lock >= 0 && !req[m_lock]) begin
        m_lock = -1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle();
    eval_cycle();
    end_cycle();
  endtask

  task automatic set_m(input int m, input logic r, input logic l, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic w, input logic [3:0] k);
    req[m]  = r;
    lck[m]  = l;
    addr[m] = a;
    wdat[m] = d;
    wren[m] = w;
    mask[m] = k;
  endtask

  task automatic set_idle();
    set_m(0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 4'h0);
    set_m(1, 1'b0, 1'b0, '0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic rand_m(input int m);
    set_m(m, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, AW'($urandom),
          $urandom, $urandom_range(0, 2) == 0, 4'($urandom));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    m_last = 1;
    m_lock = -1;
    g_now  = -1;
    for (int k = 0; k < 8; k++) begin
      sched1[k] = 0;
      sched3[k] = 0;
    end
    mem_rd = 32'h0;
    rst    = 1'b1;
    set_idle();
    @(negedge clk);

    // Reset held with both masters requesting: no grant, no valid, no rvalid.
    set_m(0, 1'b1, 1'b0, AW'(4), 32'h0, 1'b0, 4'hF);
    set_m(1, 1'b1, 1'b0, AW'(8), 32'h0, 1'b0, 4'hF);
    cycle();
    cycle();
    rst = 1'b0;
    set_idle();
    cycle();

    // Single master-0 read of 0x10 returning 0xDEADBEEF one cycle later.
    set_m(0, 1'b1, 1'b0, AW'(32'h10), 32'h0, 1'b0, 4'hF);
    eval_cycle();
    check("t1_gnt", bus1.o_m0_gnt, 1'b1);
    end_cycle();
    set_idle();
    mem_rd = 32'hDEADBEEF;
    eval_cycle();
    check("t1_rvalid", bus1.o_m0_rvalid, 1'b1);
    check("t1_rdata", bus1.o_m0_rdata, 32'hDEADBEEF);
    check("t1_no_m1", bus1.o_m1_rvalid, 1'b0);
    end_cycle();

    // Fresh reset, then both masters read continuously: strict alternation from master 0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1'b1, 1'b0, AW'(32'h100 + i), 32'h0, 1'b0, 4'hF);
      set_m(1, 1'b1, 1'b0, AW'(32'h200 + i), 32'h0, 1'b0, 4'hF);
      mem_rd = 32'hA000_0000 + i;
      eval_cycle();
      check("rr_gnt0", bus1.o_m0_gnt, (i % 2) == 0);
      end_cycle();
    end
    set_idle();
    for (int i = 0; i < 4; i++) begin
      mem_rd = 32'hB000_0000 + i;
      cycle();
    end

    // Master 1 holds the lock for three transfers while master 0 waits.
    set_m(0, 1'b1, 1'b0, AW'(32'h300), 32'h0, 1'b0, 4'hF);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1'b1, 1'b1, AW'(32'h400 + i), 32'h0, 1'b0, 4'hF);
      eval_cycle();
      check("lk_m0_blocked", bus1.o_m0_gnt, 1'b0);
      check("lk_m1_gnt", bus1.o_m1_gnt, 1'b1);
      end_cycle();
    end
    set_m(1, 1'b1, 1'b0, AW'(32'h410), 32'h0, 1'b0, 4'hF);
    eval_cycle();
    check("lk_release_m1", bus1.o_m1_gnt, 1'b1);
    end_cycle();
    set_m(1, 1'b1, 1'b0, AW'(32'h420), 32'h0, 1'b0, 4'hF);
    eval_cycle();
    check("lk_after_m0", bus1.o_m0_gnt, 1'b1);
    end_cycle();
    set_idle();
    eval_cycle();
    check("lk_m1_late", bus1.o_m1_gnt, 1'b0);
    end_cycle();
    for (int i = 0; i < 4; i++) cycle();

    // Master-0 write with partial mask: wren asserted, no read return.
    set_m(0, 1'b1, 1'b0, AW'(32'h20), 32'h12345678, 1'b1, 4'b0011);
    eval_cycle();
    check("wr_wren", bus1.o_mem_wren, 1'b1);
    check("wr_mask", 32'(bus1.o_mem_mask), 32'h3);
    check("wr_data", bus1.o_mem_data, 32'h12345678);
    end_cycle();
    set_idle();
    for (int i = 0; i < 4; i++) cycle();

    // Two reads in flight, then reset: latency-3 returns never appear; m0 wins afterwards.
    set_m(0, 1'b1, 1'b0, AW'(32'h30), 32'h0, 1'b0, 4'hF);
    cycle();
    set_m(0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 4'h0);
    set_m(1, 1'b1, 1'b1, AW'(32'h34), 32'h0, 1'b0, 4'hF);
    cycle();
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, AW'(32'h38), 32'h0, 1'b0, 4'hF);
    set_m(1, 1'b1, 1'b0, AW'(32'h3C), 32'h0, 1'b0, 4'hF);
    cycle();
    rst = 1'b0;
    eval_cycle();
    check("rst_first_m0", bus3.o_m0_gnt, 1'b1);
    end_cycle();
    set_idle();
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      if (i < 2) check("rst_no_stale", bus3.o_m1_rvalid, 1'b0);
      end_cycle();
    end

    // Lock owner goes idle for a cycle: lock drops, other master then granted.
    set_m(0, 1'b1, 1'b1, AW'(32'h50), 32'h0, 1'b0, 4'hF);
    cycle();
    set_m(0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 4'h0);
    set_m(1, 1'b1, 1'b0, AW'(32'h60), 32'h0, 1'b0, 4'hF);
    eval_cycle();
    check("idle_lock_hold", bus1.o_m1_gnt, 1'b0);
    end_cycle();
    eval_cycle();
    check("idle_lock_free", bus1.o_m1_gnt, 1'b1);
    end_cycle();
    set_idle();
    for (int i = 0; i < 4; i++) cycle();

    // Random traffic: each master holds its request until granted.
    rand_m(0);
    rand_m(1);
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      mem_rd = $urandom;
      cycle();
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || g_now == m) rand_m(m);
      end
    end
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < 5; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
